// File: rtl/xor_gate.sv
// Bitwise XOR cell with an optional output register and a saturating counter
// of cycles in which the operands differ.
module xor_gate #(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned REGISTER_OUT = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] diff_cnt,
  output logic             diff_any
);

  logic [WIDTH-1:0] w_x;
  logic [CNT_W-1:0] w_cnt_d;
  logic [CNT_W-1:0] r_cnt;

  assign w_x      = in_a ^ in_b;
  assign diff_any = |w_x;

  if (REGISTER_OUT != 0) begin : g_reg_out
    logic [WIDTH-1:0] r_out;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_out <= '0;
      end else begin
        r_out <= w_x;
      end
    end

    assign out = r_out;
  end else begin : g_comb_out
    assign out = w_x;
  end

  // Clear wins over counting; the count sticks at all-ones instead of wrapping.
  always_comb begin
    w_cnt_d = r_cnt;
    if (cnt_clr) begin
      w_cnt_d = '0;
    end else if (diff_any && (r_cnt != {CNT_W{1'b1}})) begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign diff_cnt = r_cnt;

endmodule

// File: tb/tb_xor_gate.sv
// Directed bench for xor_gate: combinational and registered 1-bit cells, an 8-bit
// cell with its mismatch counter, and a 3-bit counter instance for saturation.
module tb_xor_gate;

  logic        clk;
  logic        rst_n;
  logic        cnt_clr;
  logic        a1, b1;
  logic [7:0]  a8, b8;
  logic        as3, bs3;

  logic        c1_out, c1_any, r1_out, r1_any, s3_out, s3_any, w8_any;
  logic [15:0] c1_cnt, r1_cnt, w8_cnt;
  logic [7:0]  w8_out;
  logic [2:0]  s3_cnt;

  int checks = 0;
  int errors = 0;

  xor_gate #(.WIDTH(1), .REGISTER_OUT(0), .CNT_W(16)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_a(a1), .in_b(b1), .cnt_clr(cnt_clr),
    .out(c1_out), .diff_cnt(c1_cnt), .diff_any(c1_any)
  );

  xor_gate #(.WIDTH(1), .REGISTER_OUT(1), .CNT_W(16)) u_r1 (
    .clk(clk), .rst_n(rst_n), .in_a(a1), .in_b(b1), .cnt_clr(cnt_clr),
    .out(r1_out), .diff_cnt(r1_cnt), .diff_any(r1_any)
  );

  xor_gate #(.WIDTH(8), .REGISTER_OUT(0), .CNT_W(16)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_a(a8), .in_b(b8), .cnt_clr(cnt_clr),
    .out(w8_out), .diff_cnt(w8_cnt), .diff_any(w8_any)
  );

  xor_gate #(.WIDTH(1), .REGISTER_OUT(0), .CNT_W(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .in_a(as3), .in_b(bs3), .cnt_clr(cnt_clr),
    .out(s3_out), .diff_cnt(s3_cnt), .diff_any(s3_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] tt_a, tt_b;
    logic [3:0] tt_out;
    tt_a   = 2'b00;
    tt_b   = 2'b00;
    tt_out = 4'b0110;

    rst_n   = 1'b0;
    cnt_clr = 1'b0;
    a1 = 1'b0; b1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00;
    as3 = 1'b0; bs3 = 1'b0;

    // Reset state
    @(posedge clk); #1;
    chk("reset_r1_out", {31'd0, r1_out}, 32'd0);
    chk("reset_w8_cnt", {16'd0, w8_cnt}, 32'd0);
    chk("reset_s3_cnt", {29'd0, s3_cnt}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Truth table: (0,0),(1,0),(0,1),(1,1) -> 0,1,1,0
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tt_a = 2'(i);
      a1 = tt_a[0];
      b1 = tt_a[1];
      tt_b = 2'(i);
      #1;
      chk($sformatf("comb_out_%0d", i), {31'd0, c1_out}, {31'd0, tt_out[i]});
      chk($sformatf("comb_any_%0d", i), {31'd0, c1_any}, {31'd0, tt_out[i]});
      @(posedge clk); #1;
      chk($sformatf("reg_out_%0d", i), {31'd0, r1_out}, {31'd0, tt_out[tt_b]});
    end

    // 8-bit patterns
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h0F;
    #1;
    chk("w8_out_a5_0f", {24'd0, w8_out}, 32'h0000_00AA);
    chk("w8_any_a5_0f", {31'd0, w8_any}, 32'd1);
    a8 = 8'h3C; b8 = 8'h3C;
    #1;
    chk("w8_out_3c_3c", {24'd0, w8_out}, 32'd0);
    chk("w8_any_3c_3c", {31'd0, w8_any}, 32'd0);

    // Counter: clear via reset, then 5 mismatching cycles
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("cnt_rst_w8", {16'd0, w8_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a8 = 8'h01; b8 = 8'h00;
    as3 = 1'b1; bs3 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("cnt_w8_5", {16'd0, w8_cnt}, 32'd5);
    chk("cnt_s3_5", {29'd0, s3_cnt}, 32'd5);

    // w8 operands now equal: holds; s3 keeps counting into saturation
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h5A;
    @(posedge clk);
    @(posedge clk); #1;
    chk("cnt_w8_hold", {16'd0, w8_cnt}, 32'd5);
    chk("cnt_s3_7", {29'd0, s3_cnt}, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    chk("cnt_w8_hold2", {16'd0, w8_cnt}, 32'd5);
    chk("cnt_s3_sat", {29'd0, s3_cnt}, 32'd7);

    // Clear pulse: s3 still differs, but the clear cycle is not counted
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    chk("clr_w8", {16'd0, w8_cnt}, 32'd0);
    chk("clr_s3", {29'd0, s3_cnt}, 32'd0);
    @(negedge clk);
    cnt_clr = 1'b0;
    @(posedge clk); #1;
    chk("after_clr_s3", {29'd0, s3_cnt}, 32'd1);
    chk("after_clr_w8", {16'd0, w8_cnt}, 32'd0);

    // Mid-run reset with differing 1-bit inputs
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_s3", {29'd0, s3_cnt}, 32'd2);
    chk("pre_rst_r1", {31'd0, r1_out}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_s3", {29'd0, s3_cnt}, 32'd0);
    chk("mid_rst_r1", {31'd0, r1_out}, 32'd0);
    chk("mid_rst_c1", {31'd0, c1_out}, 32'd1);
    @(posedge clk); #1;
    chk("mid_rst_r1_hold", {31'd0, r1_out}, 32'd0);
    chk("mid_rst_s3_hold", {29'd0, s3_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_r1", {31'd0, r1_out}, 32'd1);
    chk("post_rst_s3", {29'd0, s3_cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
